// File: rtl/ripple_carry_adder.sv
// Registered N-bit ripple-carry adder: a plain chain of full-adder stages
// feeding a single output register stage with asynchronous active-low clear.
module ripple_carry_adder #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] Inp1,
  input  logic [N-1:0] Inp2,
  input  logic         Cin,
  output logic [N-1:0] Result,
  output logic         Cout
);

  logic [N:0]   carry;
  logic [N-1:0] sum;

  assign carry[0] = Cin;

  // Each stage only sees its neighbour's carry; no lookahead or select paths.
  for (genvar i = 0; i < N; i++) begin : g_stage
    logic half;
    assign half       = Inp1[i] ^ Inp2[i];
    assign sum[i]     = half ^ carry[i];
    assign carry[i+1] = (Inp1[i] & Inp2[i]) | (carry[i] & half);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result <= '0;
      Cout   <= 1'b0;
    end else begin
      Result <= sum;
      Cout   <= carry[N];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and random checks of ripple_carry_adder at N = 10 and N = 1,
// each vector compared one clock after it is applied.
module tb_ripple_carry_adder;

  logic       clk;
  logic       rst_n;
  logic [9:0] a;
  logic [9:0] b;
  logic       ci;
  logic [9:0] result;
  logic       cout;

  logic       a1;
  logic       b1;
  logic       ci1;
  logic       result1;
  logic       cout1;

  int n_checks = 0;
  int n_pass   = 0;

  ripple_carry_adder #(.N(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Inp1   (a),
    .Inp2   (b),
    .Cin    (ci),
    .Result (result),
    .Cout   (cout)
  );

  ripple_carry_adder #(.N(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .Inp1   (a1),
    .Inp2   (b1),
    .Cin    (ci1),
    .Result (result1),
    .Cout   (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // Apply one vector, clock it in, then compare both outputs.
  task automatic step10(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic c, input logic [9:0] exp_r, input logic exp_c);
    a  = x;
    b  = y;
    ci = c;
    @(posedge clk);
    #1;
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_cout"}, 32'(cout), 32'(exp_c));
  endtask

  initial begin
    logic [10:0] ref_sum;
    logic [1:0]  ref1;
    logic [9:0]  held_r;
    logic        held_c;

    rst_n = 1'b1;
    a = 10'd5;  b = 10'd7;  ci = 1'b0;
    a1 = 1'b0;  b1 = 1'b0;  ci1 = 1'b0;

    // Get a nonzero value registered so the asynchronous clear is observable.
    @(posedge clk);
    #1;
    check("preload", 32'(result), 32'd12);

    #1;
    rst_n = 1'b0;
    a = 10'd1023; b = 10'd1023; ci = 1'b1;
    #1;
    check("async_rst_result", 32'(result), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);

    repeat (2) begin
      @(posedge clk);
      #1;
      a = 10'(a - 10'd37);
    end
    check("rst_hold_result", 32'(result), 32'd0);
    check("rst_hold_cout", 32'(cout), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    step10("basic", 10'd250, 10'd400, 1'b0, 10'd650, 1'b0);

    // Clear between edges must drop the pending 650 before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step10("first_after_rst", 10'd250, 10'd400, 1'b0, 10'd650, 1'b0);
    step10("wrap", 10'd750, 10'd300, 1'b0, 10'd26, 1'b1);
    step10("cin", 10'd250, 10'd400, 1'b1, 10'd651, 1'b0);
    step10("carry_all", 10'd1023, 10'd0, 1'b1, 10'd0, 1'b1);
    step10("max", 10'd1023, 10'd1023, 1'b1, 10'd1023, 1'b1);
    step10("zero", 10'd0, 10'd0, 1'b0, 10'd0, 1'b0);
    step10("exact_2n", 10'd512, 10'd512, 1'b0, 10'd0, 1'b1);
    step10("just_below", 10'd512, 10'd510, 1'b1, 10'd1023, 1'b0);

    // Outputs must not follow input changes between edges.
    held_r = result;
    held_c = cout;
    a = 10'd1; b = 10'd2; ci = 1'b0;
    #3;
    check("hold_result", 32'(result), 32'd1023);
    check("hold_cout", 32'(cout), 32'd0);
    a = 10'd900; b = 10'd900;
    #1;
    check("hold_result2", 32'(result), 32'(held_r));
    check("hold_cout2", 32'(cout), 32'(held_c));

    for (int i = 0; i < 8; i++) begin
      a1  = i[0];
      b1  = i[1];
      ci1 = i[2];
      ref1 = 2'(a1) + 2'(b1) + 2'(ci1);
      @(posedge clk);
      #1;
      check("n1_sum", 32'({cout1, result1}), 32'(ref1));
    end

    for (int i = 0; i < 1200; i++) begin
      a  = 10'($urandom_range(0, 1023));
      b  = 10'($urandom_range(0, 1023));
      ci = 1'($urandom_range(0, 1));
      ref_sum = 11'(a) + 11'(b) + 11'(ci);
      @(posedge clk);
      #1;
      check("rand_sum", 32'({cout, result}), 32'(ref_sum));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
